imu_i2c_reader: RTL and testbench

Fixed-sequence I2C master that burst-reads `NBYTES` consecutive registers from the IMU and presents them as one packed word to the position integrator. It owns the `SCL`/`SDA_oen`/`SDA_out`/`SDA_in` pins that the position top level exports. It is triggered by a one-cycle `start` pulse, which the integrator generates from the IMU data-ready interrupt.

---
 rtl/imu_i2c_reader.sv | 195 +++++++++++++++++++
 tb/tb_imu_i2c_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_i2c_reader.sv
// imu_i2c_reader: fixed-sequence I2C master that burst-reads NBYTES consecutive
// IMU registers and presents them as one packed word, first byte in the MSBs.
module imu_i2c_reader #(
  parameter int unsigned CLK_DIV   = 125,
  parameter logic [6:0]  DEV_ADDR  = 7'h68,
  parameter logic [7:0]  START_REG = 8'h3B,
  parameter int unsigned NBYTES    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  nack,
  output logic [8*NBYTES-1:0]   data_out,
  output logic                  SCL,
  output logic                  SDA_oen,
  output logic                  SDA_out,
  input  logic                  SDA_in
);

  localparam int unsigned   DW         = 8 * NBYTES;
  localparam int unsigned   PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_BYTE  = 4'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WADDR, S_WREG, S_RSTART, S_RADDR, S_READ, S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_phase;
  logic [1:0]    r_quarter;
  logic [3:0]    r_bit;
  logic [3:0]    r_byte;
  logic          r_sample;
  logic          r_failed;
  logic          r_done;
  logic          r_nack;
  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_data_out;

  logic          w_tick;
  logic          w_sym_end;
  logic          w_sample_pt;
  logic          w_byte_state;
  logic          w_ack_bit;
  logic          w_last_byte;
  logic          w_scl_high;
  logic [2:0]    w_bit_idx;
  logic [7:0]    w_tx_byte;

  assign w_tick       = (r_phase == PHASE_LAST);
  assign w_sym_end    = w_tick && (r_quarter == 2'd3);
  assign w_sample_pt  = w_tick && (r_quarter == 2'd1);
  assign w_byte_state = (r_state == S_WADDR) || (r_state == S_WREG) ||
                        (r_state == S_RADDR) || (r_state == S_READ);
  assign w_ack_bit    = (r_bit == 4'd8);
  assign w_last_byte  = (r_byte == LAST_BYTE);
  assign w_scl_high   = (r_quarter == 2'd1) || (r_quarter == 2'd2);
  assign w_bit_idx    = 3'd7 - r_bit[2:0];

  always_comb begin
    case (r_state)
      S_WADDR: w_tx_byte = {DEV_ADDR, 1'b0};
      S_WREG:  w_tx_byte = START_REG;
      default: w_tx_byte = {DEV_ADDR, 1'b1};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Symbol timing, bit/byte counters and the receive shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase   <= '0;
      r_quarter <= 2'd0;
      r_bit     <= 4'd0;
      r_byte    <= 4'd0;
      r_sample  <= 1'b1;
      r_failed  <= 1'b0;
      r_shift   <= '0;
    end else if (r_state == S_IDLE) begin
      r_phase   <= '0;
      r_quarter <= 2'd0;
      r_bit     <= 4'd0;
      r_byte    <= 4'd0;
      if (start) begin
        r_failed <= 1'b0;
      end
    end else begin
      r_phase <= w_tick ? '0 : r_phase + 1'b1;
      if (w_tick) begin
        r_quarter <= r_quarter + 2'd1;
      end
      if (w_sample_pt) begin
        r_sample <= SDA_in;
        if (r_state == S_READ && !w_ack_bit) begin
          r_shift <= {r_shift[DW-2:0], SDA_in};
        end
      end
      if (w_sym_end && w_byte_state) begin
        r_bit <= w_ack_bit ? 4'd0 : r_bit + 4'd1;
        if (r_state == S_READ && w_ack_bit) begin
          r_byte <= r_byte + 4'd1;
        end
      end
      // Any early jump to STOP from a write/address phase is a slave NACK.
      if (w_sym_end && w_next == S_STOP && r_state != S_READ) begin
        r_failed <= 1'b1;
      end
    end
  end

  // Completion: data_out moves only on success; done and nack are exclusive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done     <= 1'b0;
      r_nack     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_done <= 1'b0;
      r_nack <= 1'b0;
      if (r_state == S_STOP && w_sym_end) begin
        r_done <= !r_failed;
        r_nack <= r_failed;
        if (!r_failed) begin
          r_data_out <= r_shift;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)     w_next = S_START;
      S_START:  if (w_sym_end) w_next = S_WADDR;
      S_WADDR:  if (w_sym_end && w_ack_bit) w_next = r_sample ? S_STOP : S_WREG;
      S_WREG:   if (w_sym_end && w_ack_bit) w_next = r_sample ? S_STOP : S_RSTART;
      S_RSTART: if (w_sym_end) w_next = S_RADDR;
      S_RADDR:  if (w_sym_end && w_ack_bit) w_next = r_sample ? S_STOP : S_READ;
      S_READ:   if (w_sym_end && w_ack_bit && w_last_byte) w_next = S_STOP;
      S_STOP:   if (w_sym_end) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    SCL     = 1'b1;
    SDA_oen = 1'b1;
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_START: begin
        SCL     = (r_quarter != 2'd3);
        SDA_oen = (r_quarter < 2'd2);
      end
      S_RSTART: begin
        SCL     = w_scl_high;
        SDA_oen = (r_quarter < 2'd2);
      end
      S_STOP: begin
        SCL     = (r_quarter != 2'd0);
        SDA_oen = (r_quarter >= 2'd2);
      end
      S_WADDR, S_WREG, S_RADDR: begin
        SCL     = w_scl_high;
        SDA_oen = w_ack_bit ? 1'b1 : w_tx_byte[w_bit_idx];
      end
      S_READ: begin
        // Master ACKs every byte but the last, which it NACKs.
        SCL     = w_scl_high;
        SDA_oen = !w_ack_bit || w_last_byte;
      end
      default: ;
    endcase
  end

  assign SDA_out  = 1'b0;
  assign done     = r_done;
  assign nack     = r_nack;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_imu_i2c_reader.sv
// Bench for imu_i2c_reader: open-drain bus with a behavioural IMU slave, a bus
// decoder and a result monitor, both compared against queued expectations.
module tb_imu_i2c_reader;

  localparam int CLK_DIV  = 4;
  localparam int NB       = 6;
  localparam int DW       = 8 * NB;
  localparam int T_START  = 1000;
  localparam int T_RSTART = 1001;
  localparam int T_STOP   = 1002;
  localparam int BUDGET   = 5000;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, nack, scl, sda_oen, sda_out, sda_in;
  logic [DW-1:0] data_out;
  logic          slave_low = 1'b0;

  // Open-drain line: pulled low by the master or the slave, else pulled up.
  assign sda_in = (sda_oen ? 1'b1 : sda_out) & ~slave_low;

  imu_i2c_reader #(
    .CLK_DIV   (CLK_DIV),
    .DEV_ADDR  (7'h68),
    .START_REG (8'h3B),
    .NBYTES    (NB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .nack     (nack),
    .data_out (data_out),
    .SCL      (scl),
    .SDA_oen  (sda_oen),
    .SDA_out  (sda_out),
    .SDA_in   (sda_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_nack;
    logic [DW-1:0] data;
    int            latency;
  } res_t;

  typedef enum {SL_IDLE, SL_ADDR, SL_WR, SL_RD} slave_t;

  res_t          exp_res[$];
  int            exp_bus[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  bit            nack_addr = 1'b0;
  bit            nack_reg  = 1'b0;
  logic [7:0]    slave_data [NB];
  logic [DW-1:0] model_data = '0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: the bus transcript and result of one burst, derived from
  // the protocol description and the slave's configured behaviour.
  task automatic expect_burst();
    int   toks[$];
    int   syms = 0;
    res_t r;
    toks.push_back(T_START);
    toks.push_back(int'(nack_addr) * 256 + 'hD0);
    if (!nack_addr) begin
      toks.push_back(int'(nack_reg) * 256 + 'h3B);
      if (!nack_reg) begin
        toks.push_back(T_RSTART);
        toks.push_back('hD1);
        for (int i = 0; i < NB; i++)
          toks.push_back(((i == NB - 1) ? 256 : 0) + int'(slave_data[i]));
      end
    end
    toks.push_back(T_STOP);
    foreach (toks[i]) syms += (toks[i] >= T_START) ? 1 : 9;
    r.is_nack = nack_addr || nack_reg;
    if (!r.is_nack)
      for (int i = 0; i < NB; i++) model_data = (model_data << 8) | DW'(slave_data[i]);
    r.data    = model_data;
    r.latency = syms * 4 * CLK_DIV;
    exp_res.push_back(r);
    foreach (toks[i]) exp_bus.push_back(toks[i]);
  endtask

  // Bus decoder and slave model, both working on SCL/SDA edges.
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  logic       sda_s;
  logic [8:0] frame = '0;
  int         bit_cnt = 0;
  int         sl_byte = 0;
  bit         in_txn = 1'b0;
  bit         addr_ack = 1'b0;
  slave_t     sl_state = SL_IDLE;

  task automatic bus_token(input int tok);
    int expv;
    expv = (exp_bus.size() != 0) ? exp_bus.pop_front() : -1;
    check("bus_token", 64'(tok), 64'(expv));
  endtask

  task automatic slave_fall();
    if (bit_cnt == 8) begin
      case (sl_state)
        SL_ADDR: begin
          addr_ack  = (frame[7:0] == 8'hD0 && !nack_addr) || frame[7:0] == 8'hD1;
          slave_low = addr_ack;
        end
        SL_WR:   slave_low = !nack_reg;
        default: slave_low = 1'b0;
      endcase
    end else if (bit_cnt == 9) begin
      bit_cnt = 0;
      case (sl_state)
        SL_ADDR: begin
          if (addr_ack && frame[1]) begin
            sl_state  = SL_RD;
            sl_byte   = 0;
            slave_low = !slave_data[0][7];
          end else begin
            sl_state  = addr_ack ? SL_WR : SL_IDLE;
            slave_low = 1'b0;
          end
        end
        SL_RD: begin
          if (!frame[0] && sl_byte < NB - 1) begin
            sl_byte++;
            slave_low = !slave_data[sl_byte][7];
          end else begin
            sl_state  = SL_IDLE;
            slave_low = 1'b0;
          end
        end
        default: slave_low = 1'b0;
      endcase
    end else if (bit_cnt >= 1 && sl_state == SL_RD) begin
      slave_low = !slave_data[sl_byte][7 - bit_cnt];
    end
  endtask

  always @(negedge clk) begin
    sda_s = sda_in;
    if (!rst) begin
      in_txn    = 1'b0;
      bit_cnt   = 0;
      sl_state  = SL_IDLE;
      slave_low = 1'b0;
    end else if (scl && scl_p && sda_p && !sda_s) begin
      bus_token(in_txn ? T_RSTART : T_START);
      in_txn    = 1'b1;
      bit_cnt   = 0;
      sl_state  = SL_ADDR;
      slave_low = 1'b0;
    end else if (scl && scl_p && !sda_p && sda_s) begin
      bus_token(T_STOP);
      in_txn    = 1'b0;
      bit_cnt   = 0;
      sl_state  = SL_IDLE;
      slave_low = 1'b0;
    end else if (scl && !scl_p) begin
      frame = {frame[7:0], sda_s};
      bit_cnt++;
      if (bit_cnt == 9) bus_token(int'({frame[0], frame[8:1]}));
    end else if (!scl && scl_p) begin
      slave_fall();
    end
    scl_p = scl;
    sda_p = sda_s;
  end

  // Result monitor: pops an expectation whenever done or nack pulses.
  int   cycle  = 0;
  int   t_busy = 0;
  logic busy_p = 1'b0;
  res_t mon_r;

  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      busy_p = 1'b0;
    end else begin
      if (busy && !busy_p) t_busy = cycle;
      if (done || nack) begin
        check("done_nack_exclusive", 64'(done && nack), 0);
        check("busy_low_at_end", 64'(busy), 0);
        if (exp_res.size() == 0) begin
          check("result_pending", 64'(exp_res.size()), 1);
        end else begin
          mon_r = exp_res.pop_front();
          check("result_is_nack", 64'(nack), 64'(mon_r.is_nack));
          check("data_out", 64'(data_out), 64'(mon_r.data));
          check("latency", 64'(cycle - t_busy), 64'(mon_r.latency));
        end
      end
      busy_p = busy;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scl"},      64'(scl), 1);
    check({tag, "_sda_oen"},  64'(sda_oen), 1);
    check({tag, "_sda_out"},  64'(sda_out), 0);
    check({tag, "_busy"},     64'(busy), 0);
    check({tag, "_done"},     64'(done), 0);
    check({tag, "_nack"},     64'(nack), 0);
    check({tag, "_data_out"}, 64'(data_out), 0);
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NB; i++) slave_data[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_res.size() != 0 || exp_bus.size() != 0) && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check("burst_within_budget", 64'(k < BUDGET), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_burst();
    expect_burst();
    pulse_start();
    wait_idle();
  endtask

  initial begin
    int k;
    for (int i = 0; i < NB; i++) slave_data[i] = 8'(i + 1);
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Nominal burst returning 0x01..0x06.
    run_burst();
    check("nominal_data", 64'(data_out), 64'h0000_0102_0304_0506);

    repeat (3) begin
      randomize_data();
      run_burst();
    end

    nack_addr = 1'b1;
    run_burst();
    nack_addr = 1'b0;
    nack_reg  = 1'b1;
    run_burst();
    nack_reg  = 1'b0;

    // Start mid-READ is ignored; start on the done cycle begins a new burst.
    randomize_data();
    expect_burst();
    pulse_start();
    repeat (600) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_mid_read", 64'(busy), 1);
    k = 0;
    while (!done && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(done), 1);
    expect_burst();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_back_to_back", 64'(busy), 1);
    wait_idle();

    // Asynchronous reset in the middle of the register byte.
    randomize_data();
    expect_burst();
    pulse_start();
    repeat (200) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_bus.delete();
    exp_res.delete();
    model_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    randomize_data();
    run_burst();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
